// File: rtl/uart_apb_tx_master.sv
// APB master that programs a 16550-style UART once after reset. It then drains a byte FIFO
// to THR, polling LSR.THRE before each write.
module uart_apb_tx_master #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1A10_0000,
    parameter logic [15:0] DIVISOR    = 16'd27,
    parameter logic [7:0]  LCR_VAL    = 8'h03
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        init_done_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [7:0] OFF_THR = 8'h00;
    localparam logic [7:0] OFF_DLL = 8'h00;
    localparam logic [7:0] OFF_DLM = 8'h04;
    localparam logic [7:0] OFF_FCR = 8'h08;
    localparam logic [7:0] OFF_LCR = 8'h0C;
    localparam logic [7:0] OFF_LSR = 8'h14;

    typedef enum logic [3:0] {
        S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_IDLE, S_POLL, S_WRITE
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_ACCESS
    } phase_e;

    typedef struct packed {
        logic [7:0] off;
        logic       write;
        logic [7:0] data;
    } apb_req_t;

    state_e   state_q, state_d;
    phase_e   phase_q, phase_d;
    apb_req_t req;

    logic             init_done_q, err_q;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full, fifo_empty, fifo_more;
    logic             push, pop;
    logic [7:0]       head;
    logic             active, xfer_done, thre;
    logic             unused_prdata;

    // ---------------- byte FIFO ----------------
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign ready_o    = !fifo_full;
    assign push       = valid_i & ready_o;
    assign pop        = xfer_done & (state_q == S_WRITE);
    assign head       = fifo_mem[rd_ptr_q];
    // Something left to send once the current head pops, counting a same-cycle push.
    assign fifo_more  = (count_q > CNT_W'(1)) | push;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- transfer decode ----------------
    always_comb begin
        req = '0;
        case (state_q)
            S_INIT0: req = '{off: OFF_LCR, write: 1'b1, data: 8'h80};
            S_INIT1: req = '{off: OFF_DLL, write: 1'b1, data: DIVISOR[7:0]};
            S_INIT2: req = '{off: OFF_DLM, write: 1'b1, data: DIVISOR[15:8]};
            S_INIT3: req = '{off: OFF_LCR, write: 1'b1, data: LCR_VAL};
            S_INIT4: req = '{off: OFF_FCR, write: 1'b1, data: 8'h07};
            S_POLL:  req = '{off: OFF_LSR, write: 1'b0, data: 8'h00};
            S_WRITE: req = '{off: OFF_THR, write: 1'b1, data: head};
            default: req = '0;
        endcase
    end

    assign active    = (phase_q != PH_IDLE);
    assign psel_o    = active;
    assign penable_o = (phase_q == PH_ACCESS);
    assign pwrite_o  = active & req.write;
    assign paddr_o   = active ? (BASE_ADDR + {24'h0, req.off}) : 32'h0;
    assign pwdata_o  = (active & req.write) ? {24'h0, req.data} : 32'h0;

    assign xfer_done = (phase_q == PH_ACCESS) & pready_i;
    // An errored LSR read is never trusted as THRE.
    assign thre      = prdata_i[5] & ~pslverr_i;
    assign unused_prdata = ^{prdata_i[31:6], prdata_i[4:0]};

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE: begin
                // Only S_IDLE parks here, except the single quiet cycle right after reset.
                if (state_q != S_IDLE) begin
                    phase_d = PH_SETUP;
                end else if (!fifo_empty || push) begin
                    state_d = S_POLL;
                    phase_d = PH_SETUP;
                end
            end
            PH_SETUP: phase_d = PH_ACCESS;
            PH_ACCESS: begin
                if (pready_i) begin
                    case (state_q)
                        S_INIT0: state_d = S_INIT1;
                        S_INIT1: state_d = S_INIT2;
                        S_INIT2: state_d = S_INIT3;
                        S_INIT3: state_d = S_INIT4;
                        S_INIT4: state_d = S_IDLE;
                        S_POLL:  state_d = thre ? S_WRITE : S_POLL;
                        S_WRITE: state_d = fifo_more ? S_POLL : S_IDLE;
                        default: state_d = S_IDLE;
                    endcase
                    phase_d = (state_d == S_IDLE) ? PH_IDLE : PH_SETUP;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INIT0;
            phase_q     <= PH_IDLE;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (xfer_done && state_q == S_INIT4) begin
                init_done_q <= 1'b1;
            end
            if (xfer_done && pslverr_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign init_done_o = init_done_q;
    assign err_o       = err_q;
    assign busy_o      = !fifo_empty | (state_q != S_IDLE);

endmodule
